load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 256, SHALL set the bus wait cycles before an access is aborted with a fault; legal range 2..65535.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-004 req_valid  in  1  SHALL signal a core memory request.
REQ-005 req_ready  out  1  SHALL signal request acceptance; it SHALL be 1 only in IDLE.
REQ-006 req_we  in  1  SHALL select store (1) or load (0).
REQ-007 req_funct3  in  3  SHALL carry the RV32I funct3: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010.
REQ-008 req_addr  in  32  SHALL carry the byte address (the ALU ADD result).
REQ-009 req_wdata  in  32  SHALL carry the store data (rs2).
REQ-010 rsp_valid / rsp_rdata / rsp_fault  out  1/32/1  SHALL be the completion pulse, load result and error flag.
REQ-011 busy  out  1  SHALL be 1 whenever the state is not IDLE; the core uses it to freeze the PC.
REQ-012 mem_valid / mem_we / mem_addr / mem_wstrb / mem_wdata  out  1/1/32/4/32  SHALL be the bus request; mem_addr SHALL be word-aligned (bits [1:0]=00).
REQ-013 mem_ready / mem_rvalid / mem_rdata  in  1/1/32  SHALL be the bus accept, read-data strobe and read data.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ, WAIT_R and RESP.
REQ-015 In IDLE, req_valid=1 SHALL capture the request into registers and move to REQ, or to RESP with fault=1 if funct3 is illegal (load 011/110/111; store >=011).
REQ-016 In REQ, mem_valid SHALL be 1 and all mem_* outputs SHALL be held stable until mem_ready=1.
REQ-017 At the REQ handshake, a store SHALL go to RESP and a load SHALL go to WAIT_R; mem_rvalid SHALL be ignored outside WAIT_R.
REQ-018 In WAIT_R, mem_rvalid=1 SHALL latch the extracted data and go to RESP.
REQ-019 RESP SHALL assert rsp_valid for exactly one cycle and then return to IDLE; rsp_rdata SHALL be 0 for stores and faults.
REQ-020 Store lanes: SB SHALL replicate the byte to all 4 lanes with wstrb=1<<addr[1:0]; SH SHALL replicate the halfword with wstrb=0011 (addr[1]=0) or 1100; SW SHALL use wstrb=1111.
REQ-021 Loads SHALL select the byte lane addr[1:0] or the halfword lane addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-022 A timeout counter SHALL clear on entry to REQ and to WAIT_R and SHALL increment each cycle in those states.
REQ-023 If the counter reaches TIMEOUT-1 without the awaited handshake, the FSM SHALL drop mem_valid, go to RESP with rsp_fault=1, and drop any late mem_rvalid.
REQ-024 Minimum latency with a zero-wait bus SHALL be: accept at cycle t, rsp_valid at t+2 for stores, rsp_valid at t+3 for loads (mem_rvalid at t+2).

Reset
REQ-025 While rst=1 the FSM SHALL be IDLE, the counter 0, and mem_valid, rsp_valid, rsp_fault, busy, rsp_rdata, mem_wstrb, mem_addr and mem_wdata SHALL all be 0; req_ready SHALL be 1.
REQ-026 Reset mid-transaction SHALL drop mem_valid immediately (asynchronously) and SHALL produce no rsp_valid for the abandoned request.

Configuration
REQ-027 With LSU_MISALIGN_TRAP_EN defined, a misaligned request (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00) SHALL skip the bus and go to RESP with rsp_fault=1.
REQ-028 Without LSU_MISALIGN_TRAP_EN, alignment bits SHALL be ignored (halfwords use addr[1] only, words ignore addr[1:0]), the access SHALL proceed, and misalignment SHALL never raise a fault.

Verification
REQ-029 SW addr=0x100 wdata=0xDEADBEEF, mem_ready=1 -> mem_addr=0x100, wstrb=1111, rsp_valid 2 cycles after accept, fault=0.
REQ-030 LB addr=0x203, mem_rdata=0x80FF_0000 -> rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-031 SH addr=0x012 wdata=0x0000ABCD -> mem_addr=0x010, wstrb=1100, wdata=0xABCDABCD; LHU addr=0x012, rdata=0xABCD1234 -> 0x0000ABCD.
REQ-032 mem_ready held 0 with TIMEOUT=4 -> mem_valid drops and rsp_fault=1 exactly 4 cycles after entering REQ; the next request is accepted normally.
REQ-033 LW addr=0x101 -> with macro: fault=1, no mem_valid; without macro: mem_addr=0x100, data returned, fault=0.
REQ-034 rst pulsed while in WAIT_R -> busy=0 and mem_valid=0 immediately, no rsp_valid; a later mem_rvalid=1 is ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-bus signals of the load/store unit.
// Latency: none (wires only).
// Backpressure: req_ready gates the core and mem_ready gates the bus; both use valid/ready.
interface load_store_unit_if;
    // core request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // core response
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;
    // memory bus request
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    // memory bus response
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // LSU view: it masters the memory bus and serves the core
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    // environment view: core plus memory
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, lane steering for stores, extraction for loads.
// Latency: accept at t, rsp_valid at t+2 (store) / t+3 (load) on a zero-wait bus; TIMEOUT bounds each bus wait.
// Backpressure: req_ready only in IDLE; mem_* held stable until mem_ready. Macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit #(
    // bus wait cycles allowed in REQ or WAIT_R before the access faults (2..65535)
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    load_store_unit_if.master bus
);

    // the counter runs 0..TIMEOUT-1, so TIMEOUT cycles are spent waiting before the fault
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } state_t;

    state_t      state;
    logic [15:0] cnt;

    // load shape kept for extraction when the read data returns
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;

    logic        f3_illegal;
    logic        misaligned;
    logic        req_fault;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    // decode funct3 legality of the incoming request
    always_comb begin
        f3_illegal = 1'b0;
        if (bus.req_we) begin
            // only SB/SH/SW exist
            f3_illegal = bus.req_funct3[2] | (bus.req_funct3[1] & bus.req_funct3[0]);
        end else begin
            // 011, 110 and 111 have no load encoding
            f3_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // halfwords need addr[0]=0, words need addr[1:0]=00; bytes are always aligned
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    // alignment bits are simply ignored by the lane logic, so nothing traps
    assign misaligned = 1'b0;
`endif

    assign req_fault = f3_illegal | misaligned;

    // steer store data onto the byte lanes selected by the low address bits
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << bus.req_addr[1:0];
                st_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = bus.req_wdata;
            end
        endcase
    end

    // pick the addressed lane of the returned word and extend it to 32 bits
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = bus.mem_rdata[7:0];
        case (ld_off)
            2'b00: lane_b = bus.mem_rdata[7:0];
            2'b01: lane_b = bus.mem_rdata[15:8];
            2'b10: lane_b = bus.mem_rdata[23:16];
            2'b11: lane_b = bus.mem_rdata[31:24];
            default: lane_b = bus.mem_rdata[7:0];
        endcase
        lane_h = ld_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (ld_funct3)
            3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_data = {24'd0, lane_b};
            3'b101:  ld_data = {16'd0, lane_h};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // access sequencer; every core and bus output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 16'd0;
            ld_funct3     <= 3'd0;
            ld_off        <= 2'd0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wstrb <= 4'd0;
            bus.mem_wdata <= 32'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        ld_funct3     <= bus.req_funct3;
                        ld_off        <= bus.req_addr[1:0];
                        if (req_fault) begin
                            // rejected requests never touch the bus
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_fault <= 1'b1;
                            bus.rsp_rdata <= 32'd0;
                        end else begin
                            state         <= REQ;
                            cnt           <= 16'd0;
                            bus.mem_valid <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wstrb <= bus.req_we ? st_wstrb : 4'd0;
                            bus.mem_wdata <= bus.req_we ? st_wdata : 32'd0;
                        end
                    end
                end

                REQ: begin
                    // mem_rvalid is deliberately not looked at here
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        cnt           <= 16'd0;
                        if (bus.mem_we) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_fault <= 1'b0;
                            bus.rsp_rdata <= 32'd0;
                        end else begin
                            state <= WAIT_R;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus.mem_valid <= 1'b0;
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_fault <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                WAIT_R: begin
                    if (bus.mem_rvalid) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_fault <= 1'b0;
                        bus.rsp_rdata <= ld_data;
                    end else if (cnt == CNT_LAST) begin
                        // a read that arrives after this point finds us out of WAIT_R and is dropped
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_fault <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RESP: begin
                    // single-cycle completion pulse, then ready for the next request
                    state         <= IDLE;
                    cnt           <= 16'd0;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_fault <= 1'b0;
                    bus.rsp_rdata <= 32'd0;
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                end

                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                    bus.mem_valid <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses against a byte-lane model.
// Latency: measured in cycles from request acceptance to rsp_valid.
// Backpressure: a reactive memory model inserts random mem_ready / mem_rvalid delays.
module tb_load_store_unit;

    localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic rst;
    load_store_unit_if lsu_if();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (lsu_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_fail = 0;

    // observations of the last transaction
    int          obs_k;
    int          obs_mv;
    logic        obs_fault;
    logic [31:0] obs_rdata;
    logic        obs_ready;
    logic        obs_hs;
    logic        obs_unstable;
    logic        obs_busy_bad;
    logic        obs_pulse_ok;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we;

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << int'(f3[1:0]);
    endfunction

    function automatic logic m_illegal(input logic we, input logic [2:0] f3);
        int v;
        v = int'(f3);
        if (we) return v >= 3;
        return (v == 3) || (v >= 6);
    endfunction

    function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = m_size(f3);
        return (int'(addr[1:0]) % sz) != 0;
    endfunction

    // first byte lane touched: the offset rounded down to the access size
    function automatic int m_first(input logic [2:0] f3, input logic [31:0] addr);
        int off;
        off = int'(addr[1:0]);
        return off - (off % m_size(f3));
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = m_size(f3);
        return 4'(((1 << sz) - 1) << m_first(f3, addr));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (m_size(f3) == 1) return {24'd0, w[7:0]} * 32'h0101_0101;
        if (m_size(f3) == 2) return {16'd0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
        int sz;
        logic [31:0] mask;
        logic [31:0] v;
        sz = m_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v = (d >> (8 * m_first(f3, addr))) & mask;
        if (!f3[2] && sz < 4 && ((v & ((mask + 32'd1) >> 1)) != 32'd0)) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver: core side + reactive memory ----------------
    // Called at a negedge with the DUT idle; returns at the negedge after the response pulse.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rdel, input int vdel);
        int   wcnt;
        int   rcnt;
        logic rd_pending;
        obs_k = 0; obs_mv = 0; obs_fault = 1'b0; obs_rdata = 32'd0; obs_hs = 1'b0;
        obs_unstable = 1'b0; obs_busy_bad = 1'b0; obs_pulse_ok = 1'b0;
        obs_addr = 32'd0; obs_wdata = 32'd0; obs_wstrb = 4'd0; obs_we = 1'b0;
        obs_ready = lsu_if.req_ready;
        lsu_if.req_valid  = 1'b1;
        lsu_if.req_we     = we;
        lsu_if.req_funct3 = f3;
        lsu_if.req_addr   = addr;
        lsu_if.req_wdata  = wdata;
        wcnt = 0; rcnt = 0; rd_pending = 1'b0;
        for (int k = 1; k <= 40 && obs_k == 0; k++) begin
            @(negedge clk);
            lsu_if.req_valid  = 1'b0;
            lsu_if.req_we     = 1'($urandom);
            lsu_if.req_funct3 = 3'($urandom);
            lsu_if.req_addr   = $urandom;
            lsu_if.req_wdata  = $urandom;
            lsu_if.mem_ready  = 1'b0;
            lsu_if.mem_rvalid = 1'b0;
            lsu_if.mem_rdata  = $urandom;
            if (lsu_if.rsp_valid === 1'b1) begin
                obs_k     = k;
                obs_fault = lsu_if.rsp_fault;
                obs_rdata = lsu_if.rsp_rdata;
                if (lsu_if.busy !== 1'b1) obs_busy_bad = 1'b1;
            end else begin
                if (lsu_if.busy !== 1'b1) obs_busy_bad = 1'b1;
                if (lsu_if.mem_valid === 1'b1) begin
                    if (obs_mv == 0) begin
                        obs_addr = lsu_if.mem_addr; obs_wdata = lsu_if.mem_wdata;
                        obs_wstrb = lsu_if.mem_wstrb; obs_we = lsu_if.mem_we;
                    end else if (obs_addr !== lsu_if.mem_addr || obs_wdata !== lsu_if.mem_wdata ||
                                 obs_wstrb !== lsu_if.mem_wstrb || obs_we !== lsu_if.mem_we) begin
                        obs_unstable = 1'b1;
                    end
                    obs_mv++;
                    // stray read strobes while the request is pending must be ignored
                    lsu_if.mem_rvalid = ($urandom_range(0, 2) == 0);
                    if (wcnt == rdel) begin
                        lsu_if.mem_ready = 1'b1;
                        obs_hs = 1'b1;
                        rd_pending = !lsu_if.mem_we;
                        rcnt = 0;
                    end
                    wcnt++;
                end else if (rd_pending) begin
                    if (rcnt == vdel) begin
                        lsu_if.mem_rvalid = 1'b1;
                        lsu_if.mem_rdata  = rdata;
                        rd_pending = 1'b0;
                    end
                    rcnt++;
                end
            end
        end
        @(negedge clk);
        lsu_if.mem_ready  = 1'b0;
        lsu_if.mem_rvalid = 1'b0;
        obs_pulse_ok = (lsu_if.rsp_valid === 1'b0) && (lsu_if.req_ready === 1'b1) && (lsu_if.busy === 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        lsu_if.req_valid = 1'b1;
        lsu_if.req_funct3 = 3'b010;
        lsu_if.req_addr = 32'h0000_1234;
        @(negedge clk);
        n_cmp++; if (lsu_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", lsu_if.req_ready); end
        n_cmp++; if (lsu_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", lsu_if.busy); end
        n_cmp++; if (lsu_if.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b want 0", lsu_if.mem_valid); end
        n_cmp++; if (lsu_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", lsu_if.rsp_valid); end
        n_cmp++; if (lsu_if.rsp_fault !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_fault: got %b want 0", lsu_if.rsp_fault); end
        n_cmp++; if (lsu_if.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", lsu_if.rsp_rdata); end
        n_cmp++; if (lsu_if.mem_wstrb !== 4'd0) begin n_fail++; $display("FAIL rst_mem_wstrb: got %h want 0", lsu_if.mem_wstrb); end
        n_cmp++; if (lsu_if.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", lsu_if.mem_addr); end
        n_cmp++; if (lsu_if.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", lsu_if.mem_wdata); end
        lsu_if.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (lsu_if.busy !== 1'b0 || lsu_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_idle: got busy=%b ready=%b want 0/1", lsu_if.busy, lsu_if.req_ready); end
    endtask

    task automatic test_store_word();
        run_txn(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 0, 0);
        n_cmp++; if (obs_k !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", obs_k); end
        n_cmp++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", obs_addr); end
        n_cmp++; if (obs_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb: got %b want 1111", obs_wstrb); end
        n_cmp++; if (obs_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", obs_wdata); end
        n_cmp++; if (obs_fault !== 1'b0 || obs_rdata !== 32'd0) begin n_fail++; $display("FAIL sw_rsp: got fault=%b rdata=%h want 0/0", obs_fault, obs_rdata); end
        n_cmp++; if (obs_pulse_ok !== 1'b1) begin n_fail++; $display("FAIL sw_pulse: got %b want 1", obs_pulse_ok); end
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, 3'b000, 32'h0000_0203, 32'd0, 32'h80FF_0000, 0, 0);
        n_cmp++; if (obs_k !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", obs_k); end
        n_cmp++; if (obs_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
        n_cmp++; if (obs_addr !== 32'h200) begin n_fail++; $display("FAIL lb_addr: got %h want 00000200", obs_addr); end
        run_txn(1'b0, 3'b100, 32'h0000_0203, 32'd0, 32'h80FF_0000, 1, 2);
        n_cmp++; if (obs_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000080", obs_rdata); end
        n_cmp++; if (obs_k !== 6) begin n_fail++; $display("FAIL lbu_latency: got %0d want 6", obs_k); end
    endtask

    task automatic test_halfword();
        run_txn(1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'd0, 0, 0);
        n_cmp++; if (obs_addr !== 32'h10) begin n_fail++; $display("FAIL sh_addr: got %h want 00000010", obs_addr); end
        n_cmp++; if (obs_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b want 1100", obs_wstrb); end
        n_cmp++; if (obs_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); end
        run_txn(1'b0, 3'b101, 32'h0000_0012, 32'd0, 32'hABCD_1234, 0, 0);
        n_cmp++; if (obs_rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL lhu_rdata: got %h want 0000abcd", obs_rdata); end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 3'b010, 32'h0000_0040, 32'h1111_2222, 32'd0, 9, 0);
        n_cmp++; if (obs_k !== 1 + TO) begin n_fail++; $display("FAIL to_req_latency: got %0d want %0d", obs_k, 1 + TO); end
        n_cmp++; if (obs_fault !== 1'b1) begin n_fail++; $display("FAIL to_req_fault: got %b want 1", obs_fault); end
        n_cmp++; if (obs_mv !== TO) begin n_fail++; $display("FAIL to_req_mv_cycles: got %0d want %0d", obs_mv, TO); end
        // handshake on the very last allowed cycle still wins
        run_txn(1'b1, 3'b010, 32'h0000_0044, 32'h3333_4444, 32'd0, TO - 1, 0);
        n_cmp++; if (obs_ready !== 1'b1 || obs_k !== TO + 1 || obs_fault !== 1'b0) begin n_fail++; $display("FAIL to_edge: got ready=%b k=%0d fault=%b want 1/%0d/0", obs_ready, obs_k, obs_fault, TO + 1); end
        run_txn(1'b0, 3'b010, 32'h0000_0048, 32'd0, 32'h5555_6666, 0, 9);
        n_cmp++; if (obs_k !== 2 + TO || obs_fault !== 1'b1 || obs_rdata !== 32'd0) begin n_fail++; $display("FAIL to_wait_r: got k=%0d fault=%b rdata=%h want %0d/1/0", obs_k, obs_fault, obs_rdata, 2 + TO); end
    endtask

    task automatic test_illegal_misalign();
        run_txn(1'b0, 3'b011, 32'h0000_0080, 32'd0, 32'h1234_5678, 0, 0);
        n_cmp++; if (obs_k !== 1 || obs_fault !== 1'b1 || obs_mv !== 0) begin n_fail++; $display("FAIL illegal_load: got k=%0d fault=%b mv=%0d want 1/1/0", obs_k, obs_fault, obs_mv); end
        run_txn(1'b1, 3'b100, 32'h0000_0080, 32'hFFFF_FFFF, 32'd0, 0, 0);
        n_cmp++; if (obs_k !== 1 || obs_fault !== 1'b1 || obs_mv !== 0) begin n_fail++; $display("FAIL illegal_store: got k=%0d fault=%b mv=%0d want 1/1/0", obs_k, obs_fault, obs_mv); end
        run_txn(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'h1122_3344, 0, 0);
        n_cmp++; if (obs_fault !== TRAP) begin n_fail++; $display("FAIL lw_misalign_fault: got %b want %b", obs_fault, TRAP); end
        n_cmp++; if (obs_mv !== (TRAP ? 0 : 1)) begin n_fail++; $display("FAIL lw_misalign_bus: got %0d want %0d", obs_mv, TRAP ? 0 : 1); end
        n_cmp++; if (obs_rdata !== (TRAP ? 32'd0 : 32'h1122_3344)) begin n_fail++; $display("FAIL lw_misalign_rdata: got %h", obs_rdata); end
        n_cmp++; if (obs_k !== (TRAP ? 1 : 3)) begin n_fail++; $display("FAIL lw_misalign_latency: got %0d want %0d", obs_k, TRAP ? 1 : 3); end
    endtask

    task automatic test_reset_mid();
        // reset while the request is on the bus
        lsu_if.req_valid = 1'b1; lsu_if.req_we = 1'b1; lsu_if.req_funct3 = 3'b010;
        lsu_if.req_addr = 32'h0000_0300; lsu_if.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        lsu_if.req_valid = 1'b0;
        n_cmp++; if (lsu_if.mem_valid !== 1'b1) begin n_fail++; $display("FAIL rm_req_mv: got %b want 1", lsu_if.mem_valid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (lsu_if.mem_valid !== 1'b0 || lsu_if.busy !== 1'b0) begin n_fail++; $display("FAIL rm_req_async: got mv=%b busy=%b want 0/0", lsu_if.mem_valid, lsu_if.busy); end
        @(negedge clk);
        rst = 1'b0;
        // reset while waiting for read data
        lsu_if.req_valid = 1'b1; lsu_if.req_we = 1'b0; lsu_if.req_funct3 = 3'b010;
        lsu_if.req_addr = 32'h0000_0400;
        @(negedge clk);
        lsu_if.req_valid = 1'b0;
        lsu_if.mem_ready = 1'b1;
        @(negedge clk);
        lsu_if.mem_ready = 1'b0;
        n_cmp++; if (lsu_if.busy !== 1'b1 || lsu_if.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rm_wait_r_state: got busy=%b mv=%b want 1/0", lsu_if.busy, lsu_if.mem_valid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (lsu_if.busy !== 1'b0 || lsu_if.mem_valid !== 1'b0 || lsu_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_wait_r_async: got busy=%b mv=%b ready=%b want 0/0/1", lsu_if.busy, lsu_if.mem_valid, lsu_if.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            lsu_if.mem_rvalid = 1'b1;
            lsu_if.mem_rdata = $urandom;
            @(negedge clk);
            n_cmp++; if (lsu_if.rsp_valid !== 1'b0 || lsu_if.busy !== 1'b0) begin n_fail++; $display("FAIL rm_late_rvalid[%0d]: got rsp=%b busy=%b want 0/0", c, lsu_if.rsp_valid, lsu_if.busy); end
        end
        lsu_if.mem_rvalid = 1'b0;
        run_txn(1'b0, 3'b001, 32'h0000_0502, 32'd0, 32'h8001_7FFF, 0, 0);
        n_cmp++; if (obs_k !== 3 || obs_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL rm_recover: got k=%0d rdata=%h want 3/ffff8001", obs_k, obs_rdata); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 3'b000, 32'h0000_0601, 32'h0000_005A, 32'd0, 0, 0);
        n_cmp++; if (obs_wstrb !== 4'b0010 || obs_wdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL b2b_sb: got wstrb=%b wdata=%h want 0010/5a5a5a5a", obs_wstrb, obs_wdata); end
        run_txn(1'b0, 3'b010, 32'h0000_0604, 32'd0, 32'h0BAD_F00D, 0, 0);
        n_cmp++; if (obs_ready !== 1'b1 || obs_k !== 3 || obs_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_lw: got ready=%b k=%0d rdata=%h want 1/3/0badf00d", obs_ready, obs_k, obs_rdata); end
    endtask

    task automatic test_random();
        logic [2:0]  lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata, erd;
        int          rdel, vdel, ek, emv;
        logic        ef, skip;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = we ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            rdel = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
            vdel = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
            run_txn(we, f3, addr, wdata, rdata, rdel, vdel);
            skip = m_illegal(we, f3) || (TRAP && m_misal(f3, addr));
            erd = 32'd0;
            if (skip) begin ek = 1; ef = 1'b1; emv = 0; end
            else if (rdel >= TO) begin ek = 1 + TO; ef = 1'b1; emv = TO; end
            else if (we) begin ek = rdel + 2; ef = 1'b0; emv = rdel + 1; end
            else if (vdel >= TO) begin ek = rdel + 2 + TO; ef = 1'b1; emv = rdel + 1; end
            else begin ek = rdel + 3 + vdel; ef = 1'b0; emv = rdel + 1; erd = m_load(f3, addr, rdata); end
            n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want 1", i, obs_ready); end
            n_cmp++; if (obs_k !== ek) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d (we=%b f3=%0d rdel=%0d vdel=%0d)", i, obs_k, ek, we, f3, rdel, vdel); end
            n_cmp++; if (obs_fault !== ef) begin n_fail++; $display("FAIL rnd_fault[%0d]: got %b want %b", i, obs_fault, ef); end
            n_cmp++; if (obs_rdata !== erd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h (f3=%0d addr=%h)", i, obs_rdata, erd, f3, addr); end
            n_cmp++; if (obs_mv !== emv) begin n_fail++; $display("FAIL rnd_mv_cycles[%0d]: got %0d want %0d", i, obs_mv, emv); end
            n_cmp++; if (obs_unstable !== 1'b0 || obs_busy_bad !== 1'b0) begin n_fail++; $display("FAIL rnd_hold[%0d]: got unstable=%b busy_bad=%b want 0/0", i, obs_unstable, obs_busy_bad); end
            n_cmp++; if (obs_pulse_ok !== 1'b1) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got %b want 1", i, obs_pulse_ok); end
            if (emv > 0) begin
                n_cmp++; if (obs_addr !== {addr[31:2], 2'b00} || obs_we !== we) begin n_fail++; $display("FAIL rnd_bus[%0d]: got addr=%h we=%b want %h/%b", i, obs_addr, obs_we, {addr[31:2], 2'b00}, we); end
                if (we) begin
                    n_cmp++; if (obs_wstrb !== m_wstrb(f3, addr)) begin n_fail++; $display("FAIL rnd_wstrb[%0d]: got %b want %b", i, obs_wstrb, m_wstrb(f3, addr)); end
                    n_cmp++; if (obs_wdata !== m_wdata(f3, wdata)) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, obs_wdata, m_wdata(f3, wdata)); end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lsu_if.req_valid = 1'b0; lsu_if.req_we = 1'b0; lsu_if.req_funct3 = 3'd0;
        lsu_if.req_addr = 32'd0; lsu_if.req_wdata = 32'd0;
        lsu_if.mem_ready = 1'b0; lsu_if.mem_rvalid = 1'b0; lsu_if.mem_rdata = 32'd0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_halfword();
        test_timeout();
        test_illegal_misalign();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
